// File: rtl/draw_command_executor.sv
// draw_command_executor
// Walks processor RAM entries 0..numCommands-1 and turns each enabled
// rectangle into a stream of one pixel per cycle for the sprite ROMs and
// the VGA adapter. While busy the executor owns the RAM read port.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   go_draw            start pulse, only looked at while idle
//   numCommands        number of valid command words
//   processor_addr     RAM read address (data returns RAM_LATENCY later)
//   processor_out      RAM read data
//   vga_x, vga_y       pixel coordinate
//   vga_plot           pixel is on screen and should be written
//   shape_type         type field of the command being drawn
//   sprite_row/col     offset of the pixel inside its shape
//   busy               list is being walked
//   draw_done          one-cycle pulse once the list is finished
module draw_command_executor #(
  parameter int RAM_LATENCY = 2,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int DASH_BIT    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go_draw,
  input  logic [9:0]  numCommands,
  output logic [9:0]  processor_addr,
  input  logic [47:0] processor_out,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic        vga_plot,
  output logic [8:0]  shape_type,
  output logic [8:0]  sprite_row,
  output logic [9:0]  sprite_col,
  output logic        busy,
  output logic        draw_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int WW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [9:0]    idx_q, idx_d;
  logic [9:0]    addr_q, addr_d;
  logic [9:0]    left_q, left_d, width_q, width_d;
  logic [8:0]    top_q, top_d, height_q, height_d;
  logic [8:0]    type_q, type_d;
  logic [8:0]    row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Command word fields
  logic       f_en;
  logic [8:0] f_type, f_h, f_top;
  logic [9:0] f_w, f_left;
  assign {f_en, f_type, f_h, f_w, f_top, f_left} = processor_out;

  // Pixel outputs for a given offset: {plot, y, x}. Sums are one bit wider
  // than the outputs so an off-screen pixel can never alias onto the screen.
  function automatic logic [19:0] pix(input logic [9:0] l, input logic [8:0] t,
                                      input logic [8:0] ty, input logic [9:0] c,
                                      input logic [8:0] r);
    logic [10:0] xw;
    logic [9:0]  yw;
    logic        pl;
    xw = {1'b0, l} + {1'b0, c};
    yw = {1'b0, t} + {1'b0, r};
    pl = (xw < 11'(H_RES)) && (yw < 10'(V_RES)) && !((ty == 9'd0) && c[DASH_BIT]);
    return {pl, yw[8:0], xw[9:0]};
  endfunction

  logic last_col, last_row;
  assign last_col = (col_q == width_q - 10'd1);
  assign last_row = (row_q == height_q - 9'd1);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    left_d   = left_q;
    top_d    = top_q;
    width_d  = width_q;
    height_d = height_q;
    type_d   = type_q;
    row_d    = row_q;
    col_d    = col_q;
    x_d      = x_q;
    y_d      = y_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (go_draw) begin
        if (numCommands == 10'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
          idx_d   = 10'd0;
          addr_d  = 10'd0;
          wait_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (wait_q == WW'(RAM_LATENCY - 1)) state_d = S_DECODE;
        else wait_d = wait_q + 1'b1;
      end
      S_DECODE: begin
        left_d   = f_left;
        top_d    = f_top;
        width_d  = f_w;
        height_d = f_h;
        type_d   = f_type;
        if (!f_en || f_h == 9'd0 || f_w == 10'd0) begin
          state_d = S_NEXT;
        end else begin
          // First pixel is registered here so it shows on the first DRAW cycle.
          state_d = S_DRAW;
          row_d   = 9'd0;
          col_d   = 10'd0;
          {plot_d, y_d, x_d} = pix(f_left, f_top, f_type, 10'd0, 9'd0);
        end
      end
      S_DRAW: begin
        if (last_col && last_row) begin
          state_d = S_NEXT;
        end else begin
          col_d = last_col ? 10'd0 : col_q + 10'd1;
          row_d = last_col ? row_q + 9'd1 : row_q;
          {plot_d, y_d, x_d} = pix(left_q, top_q, type_q, col_d, row_d);
        end
      end
      S_NEXT: begin
        if (idx_q + 10'd1 == numCommands) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
          idx_d   = idx_q + 10'd1;
          addr_d  = idx_q + 10'd1;
          wait_d  = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      left_q   <= '0;
      top_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      type_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      top_q    <= top_d;
      width_q  <= width_d;
      height_q <= height_d;
      type_q   <= type_d;
      row_q    <= row_d;
      col_q    <= col_d;
      x_q      <= x_d;
      y_q      <= y_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign processor_addr = addr_q;
  assign vga_x          = x_q;
  assign vga_y          = y_q;
  assign vga_plot       = plot_q;
  assign shape_type     = type_q;
  assign sprite_row     = row_q;
  assign sprite_col     = col_q;
  assign busy           = busy_q;
  assign draw_done      = done_q;

endmodule

// File: tb/tb_draw_command_executor.sv
module tb_draw_command_executor;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go_draw;
  logic [9:0]  numCommands;
  logic [9:0]  processor_addr;
  logic [47:0] processor_out;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic        vga_plot;
  logic [8:0]  shape_type;
  logic [8:0]  sprite_row;
  logic [9:0]  sprite_col;
  logic        busy;
  logic        draw_done;

  always #5 clk = ~clk;

  draw_command_executor dut (
    .clk(clk), .resetn(resetn), .go_draw(go_draw), .numCommands(numCommands),
    .processor_addr(processor_addr), .processor_out(processor_out),
    .vga_x(vga_x), .vga_y(vga_y), .vga_plot(vga_plot), .shape_type(shape_type),
    .sprite_row(sprite_row), .sprite_col(sprite_col), .busy(busy), .draw_done(draw_done)
  );

  // RAM model with 2-cycle address-to-data latency
  logic [47:0] ram [0:7];
  logic [9:0]  a1, a2;
  always @(posedge clk) begin
    a1 <= processor_addr;
    a2 <= a1;
  end
  assign processor_out = ram[a2[2:0]];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  logic [18:0] plots[$];   // {y, x}
  logic [9:0]  addrs[$];
  int first_k, done_k, ndone, nbusy_lo;

  // Start the list and watch the stream; k counts cycles after acceptance.
  task automatic run(input int n, input int maxc, input int inj);
    plots.delete();
    addrs.delete();
    addrs.push_back(processor_addr);
    first_k = -1; done_k = -1; ndone = 0; nbusy_lo = 0;
    numCommands = 10'(n);
    @(negedge clk); go_draw = 1'b1;
    @(negedge clk); go_draw = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      if (k > 1) @(negedge clk);
      go_draw = (k == inj);
      if (vga_plot) begin
        plots.push_back({vga_y, vga_x});
        if (first_k < 0) first_k = k;
      end
      if (processor_addr != addrs[$]) addrs.push_back(processor_addr);
      if (draw_done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end else if (!busy && done_k < 0) nbusy_lo++;
      if (done_k > 0 && k == done_k + 2) break;
    end
    go_draw = 1'b0;
    if (done_k < 0) chk("timeout", 0, 1);
  endtask

  initial begin
    logic [18:0] exp1 [0:5];
    exp1[0] = {9'd10, 10'd100}; exp1[1] = {9'd10, 10'd101};
    exp1[2] = {9'd11, 10'd100}; exp1[3] = {9'd11, 10'd101};
    exp1[4] = {9'd12, 10'd100}; exp1[5] = {9'd12, 10'd101};
    for (int i = 0; i < 8; i++) ram[i] = '0;
    resetn = 1'b0; go_draw = 1'b0; numCommands = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {vga_plot, busy, draw_done, vga_x, vga_y, processor_addr}, 0);
    chk("rst_sprite", {shape_type, sprite_row, sprite_col}, 0);
    @(negedge clk); resetn = 1'b1;

    // 2x3 rectangle
    ram[0] = {1'b1, 9'd1, 9'd3, 10'd2, 9'd10, 10'd100};
    run(1, 40, 0);
    chk("t1_nplots", plots.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < plots.size()) chk($sformatf("t1_pix%0d", i), plots[i], exp1[i]);
    chk("t1_first", first_k, 4);
    chk("t1_done_k", done_k, 11);
    chk("t1_ndone", ndone, 1);
    chk("t1_type", shape_type, 1);

    // Dashed line, 620 wide x 2 high
    ram[0] = {1'b1, 9'd0, 9'd2, 10'd620, 9'd40, 10'd10};
    run(1, 1400, 0);
    chk("dash_nplots", plots.size(), 624);
    if (plots.size() > 8) begin
      chk("dash_p7", plots[7], {9'd40, 10'd17});
      chk("dash_p8", plots[8], {9'd40, 10'd26});
    end
    if (plots.size() > 312) chk("dash_row1", plots[312], {9'd41, 10'd10});
    chk("dash_done_k", done_k, 1245);

    // Three commands, middle one disabled
    ram[0] = {1'b1, 9'd2, 9'd1, 10'd2, 9'd5, 10'd0};
    ram[1] = {1'b0, 9'd2, 9'd4, 10'd4, 9'd5, 10'd50};
    ram[2] = {1'b1, 9'd3, 9'd1, 10'd1, 9'd7, 10'd20};
    run(3, 60, 0);
    chk("skip_nplots", plots.size(), 3);
    if (plots.size() == 3) begin
      chk("skip_p0", plots[0], {9'd5, 10'd0});
      chk("skip_p1", plots[1], {9'd5, 10'd1});
      chk("skip_p2", plots[2], {9'd7, 10'd20});
    end
    chk("skip_naddr", addrs.size(), 3);
    if (addrs.size() == 3) chk("skip_addr", {addrs[0], addrs[1], addrs[2]}, {10'd0, 10'd1, 10'd2});
    chk("skip_done_k", done_k, 16);
    chk("skip_ndone", ndone, 1);
    chk("skip_type", shape_type, 3);

    // Clipping at the bottom-right corner
    ram[0] = {1'b1, 9'd1, 9'd4, 10'd8, 9'd478, 10'd636};
    run(1, 60, 0);
    chk("clip_nplots", plots.size(), 8);
    if (plots.size() == 8) begin
      chk("clip_first", plots[0], {9'd478, 10'd636});
      chk("clip_last", plots[7], {9'd479, 10'd639});
    end
    chk("clip_busy", nbusy_lo, 0);
    chk("clip_done_k", done_k, 37);

    // Empty list
    run(0, 10, 0);
    chk("empty_done_k", done_k, 1);
    chk("empty_nplots", plots.size(), 0);
    chk("empty_addr", processor_addr, 0);
    chk("empty_ndone", ndone, 1);

    // Reset in the middle of a 4x3 rectangle
    ram[0] = {1'b1, 9'd1, 9'd3, 10'd4, 9'd0, 10'd0};
    numCommands = 10'd1;
    @(negedge clk); go_draw = 1'b1;
    @(negedge clk); go_draw = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_pix", {vga_plot, vga_y, vga_x}, {1'b1, 9'd0, 10'd2});
    resetn = 1'b0;
    #1;
    chk("mid_rst_outs", {vga_plot, busy, draw_done, vga_x, vga_y, processor_addr}, 0);
    chk("mid_rst_sprite", {shape_type, sprite_row, sprite_col}, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_done", draw_done, 0);
    resetn = 1'b1;

    // Restart, with a go_draw pulse while busy that must be ignored
    run(1, 60, 5);
    chk("rs_nplots", plots.size(), 12);
    if (plots.size() == 12) chk("rs_p0", plots[0], {9'd0, 10'd0});
    chk("rs_naddr", addrs.size(), 1);
    chk("rs_done_k", done_k, 17);
    chk("rs_ndone", ndone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/draw_command_executor.md
Name: draw_command_executor

Overview:
- Back end of the draw-processor command list. Walks processor RAM entries 0..numCommands-1 and rasterises each enabled rectangle into a per-pixel stream (x, y, shape type, in-shape offset, plot strobe).
- Downstream sprite ROMs and the VGA adapter consume the stream. The executor owns the RAM read port while busy.

Parameters:
- RAM_LATENCY, 2, cycles from processor_addr change to valid processor_out
- H_RES, 640, pixels per line; x >= H_RES is clipped
- V_RES, 480, lines per frame; y >= V_RES is clipped
- DASH_BIT, 3, column bit that blanks dashed lines (type 0) when set

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- go_draw  in  1  start pulse; sampled only in IDLE
- numCommands  in  10  count of valid command words
- processor_addr  out  10  RAM read address
- processor_out  in  48  RAM read data
- vga_x  out  10  pixel x
- vga_y  out  9  pixel y
- vga_plot  out  1  pixel valid this cycle
- shape_type  out  9  type field of the current command
- sprite_row  out  9  row offset within the shape
- sprite_col  out  10  column offset within the shape
- busy  out  1  high from go_draw acceptance until draw_done
- draw_done  out  1  one-cycle pulse when the list is finished

Behaviour:
- Command word fields: [47] enable, [46:38] type, [37:29] height, [28:19] width, [18:10] top, [9:0] left.
- Reset (async, resetn=0): state=IDLE. processor_addr, vga_x, vga_y, shape_type, sprite_row, sprite_col are 0. vga_plot, busy, draw_done are 0. Wait counter and command index are 0.
- IDLE:
  - go_draw=1 and numCommands=0 -> DONE.
  - go_draw=1 otherwise -> FETCH. Set index=0, processor_addr=0, busy=1.
- FETCH: wait RAM_LATENCY cycles with processor_addr held, then -> DECODE.
- DECODE: latch all fields into internal registers and drive shape_type.
  - enable=0, height=0 or width=0 -> NEXT (no pixels).
  - Otherwise -> DRAW with row=0, col=0.
- DRAW: one pixel per cycle, raster order.
  - col increments first. At col=width-1, col returns to 0 and row increments.
  - After row=height-1, col=width-1 -> NEXT.
  - Outputs per cycle: vga_x=left+col, vga_y=top+row, sprite_col=col, sprite_row=row, all registered.
  - Sums are computed one bit wider than the output.
  - vga_plot=1 unless any of: wide sum of x >= H_RES; wide sum of y >= V_RES; type=0 and col[DASH_BIT]=1.
  - Clipped pixels still take their cycle. Coordinates never wrap onto the screen.
- NEXT:
  - vga_plot=0.
  - If index+1 = numCommands -> DONE.
  - Otherwise index++, processor_addr=index, -> FETCH.
- DONE: draw_done=1 and busy=0 for exactly one cycle, -> IDLE.
- Latency:
  - go_draw accepted at cycle N. processor_addr valid at N+1.
  - DECODE at N+1+RAM_LATENCY. First pixel at N+2+RAM_LATENCY.
  - Each further command costs 1 (NEXT) + RAM_LATENCY + 1 (DECODE) overhead cycles.
- go_draw while busy is ignored. numCommands is sampled in NEXT, so the writer must not change it while busy.
- vga_plot is 0 in every state except DRAW.
- Reset mid-operation aborts immediately to the reset state, with no draw_done.

Test Plan:
- numCommands=1, word {1,9'd1,9'd3,10'd2,9'd10,10'd100}, go_draw -> exactly 6 plots in order (100,10),(101,10),(100,11),(101,11),(100,12),(101,12), then one draw_done pulse. First plot at cycle N+4.
- Dashed line {1,0,2,620,40,10} -> first row plots at x=10..17, 26..33, ... only (col[3]=0). Total cycles in DRAW = 1240.
- Three commands with word 1 enable=0 -> pixels from words 0 and 2 only. processor_addr sequence 0,1,2. One draw_done.
- Clip: {1,1,4,8,478,636} -> plots only at x 636..639, y 478..479 (8 plots). busy stays high for all 32 DRAW cycles.
- numCommands=0, go_draw -> draw_done one cycle later, no plots, processor_addr stays 0.
- Assert resetn low mid-DRAW -> all outputs 0 the same cycle. After release, go_draw restarts from address 0. A go_draw pulse while busy has no effect.
